seq_muldiv: RTL

Sequential unsigned 16-bit multiply/divide unit that sits directly downstream of the register file. It consumes the two register-file read ports (R, S) on a debounced start pulse and iterates one bit per clock (shift-add multiply, restoring divide). It presents a 32-bit result that the display controller shows in place of the raw {R,S} pair.

---
 rtl/seq_muldiv.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/seq_muldiv.sv
// Sequential unsigned multiply/divide unit: shift-add multiply and restoring divide,
// one bit per clock, 2*WIDTH-bit result held until the next accepted start.
module seq_muldiv #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               op,
   input  logic [WIDTH-1:0]   R,
   input  logic [WIDTH-1:0]   S,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero,
   output logic [2*WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic               busy_next;
   logic               done_next;
   logic               op_r;
   logic               dbz_pend;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH:0]     work_hi;
   logic [WIDTH-1:0]   work_lo;
   logic [WIDTH:0]     iter_hi;
   logic [WIDTH-1:0]   iter_lo;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     trial;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; a divide by zero takes a single pass through RUN
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (dbz_pend || (cnt == LAST)) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_RUN;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Output decode, registered below so busy/done align with the state they describe
   always_comb begin
      busy_next = 1'b0;
      done_next = 1'b0;
      if (state_next != ST_IDLE) begin
         busy_next = 1'b1;
      end else begin
         busy_next = 1'b0;
      end
      if (state_next == ST_DONE) begin
         done_next = 1'b1;
      end else begin
         done_next = 1'b0;
      end
   end

   // Registered status outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= busy_next;
         done <= done_next;
      end
   end

   // One iteration step; both algorithms leave their answer in {hi[W-1:0], lo}
   always_comb begin
      sum     = '0;
      shifted = '0;
      trial   = '0;
      iter_hi = work_hi;
      iter_lo = work_lo;
      if (op_r) begin
         shifted = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
         trial   = shifted - {1'b0, opnd};
         if (trial[WIDTH]) begin
            iter_hi = shifted;
         end else begin
            iter_hi = trial;
         end
         iter_lo = {work_lo[WIDTH-2:0], ~trial[WIDTH]};
      end else begin
         if (work_lo[0]) begin
            sum = {1'b0, work_hi[WIDTH-1:0]} + {1'b0, opnd};
         end else begin
            sum = {1'b0, work_hi[WIDTH-1:0]};
         end
         iter_hi = {1'b0, sum[WIDTH:1]};
         iter_lo = {sum[0], work_lo[WIDTH-1:1]};
      end
   end

   // Datapath: operand capture, iteration, result commit on entry to DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_r        <= 1'b0;
         dbz_pend    <= 1'b0;
         cnt         <= '0;
         opnd        <= '0;
         work_hi     <= '0;
         work_lo     <= '0;
         div_by_zero <= 1'b0;
         result      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_r        <= op;
                  dbz_pend    <= op && (S == '0);
                  cnt         <= '0;
                  opnd        <= op ? S : R;
                  work_hi     <= '0;
                  work_lo     <= op ? R : S;
                  div_by_zero <= 1'b0;
               end
            end
            ST_RUN: begin
               if (dbz_pend) begin
                  result      <= {work_lo, {WIDTH{1'b1}}};
                  div_by_zero <= 1'b1;
               end else begin
                  work_hi <= iter_hi;
                  work_lo <= iter_lo;
                  cnt     <= cnt + CW'(1);
                  if (cnt == LAST) begin
                     result <= {iter_hi[WIDTH-1:0], iter_lo};
                  end
               end
            end
            default: begin
               cnt <= cnt;
            end
         endcase
      end
   end

endmodule
